oversample_frame_ctrl: RTL and testbench

//  Sequences majority-vote bit recovery for an oversampled serial line. Detects a start

---
 rtl/oversample_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_oversample_frame_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oversample_frame_ctrl.sv
// Majority-vote frame recovery for an oversampled serial line.
// Define MAJ_PARITY_EN to add an even-parity window between data and stop.
module oversample_frame_ctrl #(
  parameter int OSR       = 17,
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
`ifdef MAJ_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd4;
`endif

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt1;
  logic [CNT_W-1:0]     cnt0;
  logic [CNT_W-1:0]     pos;
  logic [DATA_BITS-1:0] shreg;
  logic                 pend;
`ifdef MAJ_PARITY_EN
  logic                 perr;
`endif

  logic [CNT_W-1:0]     n1;
  logic [CNT_W-1:0]     n0;
  logic [CNT_W:0]       total;
  logic                 close;
  logic                 vote;

  // counts including the current sample; the closing sample is part of its window
  always_comb begin
    n1    = cnt1 + CNT_W'(in);
    n0    = cnt0 + CNT_W'(!in);
    total = {1'b0, n1} + {1'b0, n0};
    close = (total == (CNT_W+1)'(OSR));
    vote  = (n1 > n0);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt1      <= '0;
      cnt0      <= '0;
      pos       <= '0;
      shreg     <= '0;
      pend      <= 1'b0;
      frame_err <= 1'b0;
`ifdef MAJ_PARITY_EN
      perr      <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      pend      <= 1'b0;
      if (en) begin
        if (state == S_IDLE) begin
          if (in) begin
            cnt1  <= CNT_W'(1);
            cnt0  <= '0;
            state <= S_START;
          end
        end else if (!close) begin
          cnt1 <= n1;
          cnt0 <= n0;
        end else begin
          cnt1 <= '0;
          cnt0 <= '0;
          unique case (state)
            S_START: begin
              pos   <= '0;
`ifdef MAJ_PARITY_EN
              perr  <= 1'b0;
`endif
              state <= vote ? S_DATA : S_IDLE;
            end
            S_DATA: begin
              shreg <= {vote, shreg[DATA_BITS-1:1]};
              pos   <= pos + CNT_W'(1);
              if (pos == CNT_W'(DATA_BITS-1)) begin
`ifdef MAJ_PARITY_EN
                state <= S_PAR;
`else
                state <= S_STOP;
`endif
              end
            end
`ifdef MAJ_PARITY_EN
            S_PAR: begin
              perr      <= (vote != ^shreg);
              frame_err <= (vote != ^shreg);
              state     <= S_STOP;
            end
`endif
            S_STOP: begin
              state <= S_IDLE;
              if (vote) begin
                frame_err <= 1'b1;
`ifdef MAJ_PARITY_EN
              end else if (!perr) begin
`else
              end else begin
`endif
                pend <= 1'b1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // shreg is untouched for at least OSR samples after stop, so it is read directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (pend) begin
        if (valid_out && !ready_in) begin
          overrun <= 1'b1;
        end else begin
          data_out  <= shreg;
          valid_out <= 1'b1;
        end
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_oversample_frame_ctrl.sv
// Randomized bench for oversample_frame_ctrl against a window-vote frame model.
// Honors MAJ_PARITY_EN when the design is built with it.
module tb_oversample_frame_ctrl;

  localparam int OSR = 17;
  localparam int DB  = 8;
`ifdef MAJ_PARITY_EN
  localparam int NW  = DB + 3;
`else
  localparam int NW  = DB + 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in;
  logic          ready_in;
  logic [DB-1:0] data_out;
  logic          valid_out;
  logic          busy;
  logic          frame_err;
  logic          overrun;

  int vectors = 0;
  int miscompares = 0;

  bit            smp[$];
  int            sstep[$];
  logic          vq[$];
  logic          eq[$];
  logic          oq[$];
  logic          bq[$];
  logic [DB-1:0] dq[$];
  int            ev_kind[$];
  int            ev_idx[$];
  logic [DB-1:0] ev_word[$];

  oversample_frame_ctrl #(
    .OSR(OSR),
    .DATA_BITS(DB),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in(in),
    .data_out(data_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .busy(busy),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input bit e, input bit i);
    en = e;
    in = i;
    @(posedge clk);
    #1;
    vq.push_back(valid_out);
    eq.push_back(frame_err);
    oq.push_back(overrun);
    bq.push_back(busy);
    dq.push_back(data_out);
  endtask

  // first sample of each window is never flipped so start detection stays aligned
  task automatic gen_window(input bit b, input int flips);
    bit w[OSR];
    int p;
    for (int j = 0; j < OSR; j++) w[j] = b;
    for (int k = 0; k < flips; k++) begin
      do p = $urandom_range(1, OSR-1); while (w[p] != b);
      w[p] = !b;
    end
    for (int j = 0; j < OSR; j++) smp.push_back(w[j]);
  endtask

  task automatic gen_frame(input logic [DB-1:0] d, input bit stopv,
                           input int flips);
    gen_window(1'b1, flips);
    for (int i = 0; i < DB; i++) gen_window(d[i], flips);
`ifdef MAJ_PARITY_EN
    gen_window(^d, flips);
`endif
    gen_window(stopv, flips);
  endtask

  function automatic bit vote_at(int p);
    int ones = 0;
    for (int j = 0; j < OSR; j++) ones += int'(smp[p+j]);
    return (2 * ones > OSR);
  endfunction

  function automatic void add_ev(int k, logic [DB-1:0] w, int idx);
    ev_kind.push_back(k);
    ev_word.push_back(w);
    ev_idx.push_back(idx);
  endfunction

  // kind 1 = good word, 2 = frame error; idx = sample index that closes it
  function automatic void model();
    int p = 0;
    int n = smp.size();
    logic [DB-1:0] w;
    bit perr;
    ev_kind.delete();
    ev_word.delete();
    ev_idx.delete();
    while (p < n) begin
      if (!smp[p]) begin
        p++;
        continue;
      end
      if (p + OSR > n) break;
      if (!vote_at(p)) begin
        p += OSR;
        continue;
      end
      if (p + NW*OSR > n) break;
      for (int i = 0; i < DB; i++) w[i] = vote_at(p + (i+1)*OSR);
      perr = 1'b0;
`ifdef MAJ_PARITY_EN
      perr = (vote_at(p + (DB+1)*OSR) != ^w);
      if (perr) add_ev(2, '0, p + (DB+2)*OSR - 1);
`endif
      if (vote_at(p + (NW-1)*OSR)) add_ev(2, '0, p + NW*OSR - 1);
      else if (!perr) add_ev(1, w, p + NW*OSR - 1);
      p += NW*OSR;
    end
  endfunction

  // mode 0: en always 1; 1: en alternates; 2: random en=0 gaps
  task automatic run(input int mode, input int tail);
    vq.delete(); eq.delete(); oq.delete(); bq.delete(); dq.delete();
    sstep.delete();
    foreach (smp[k]) begin
      if (mode == 1 && k > 0) step(1'b0, 1'($urandom));
      if (mode == 2) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++)
          step(1'b0, 1'($urandom));
      end
      step(1'b1, smp[k]);
      sstep.push_back(vq.size());
    end
    repeat (tail) step(1'b1, 1'b0);
  endtask

  // expectations with ready_in held at 1
  task automatic check_events(input string tag);
    int nv = 0, ne = 0, no = 0, gv = 0, ge = 0, c;
    foreach (ev_kind[i]) begin
      c = sstep[ev_idx[i]];
      if (ev_kind[i] == 1) begin
        gv++;
        vectors++;
        if (c + 1 >= vq.size()) begin
          miscompares++;
          $display("FAIL %s log short: steps=%0d need=%0d", tag, vq.size(), c+2);
        end else begin
          if (vq[c] !== 1'b1 || dq[c] !== ev_word[i]) begin
            miscompares++;
            $display("FAIL %s word@%0d: valid=%b data=%h, want valid=1 data=%h",
                     tag, c+1, vq[c], dq[c], ev_word[i]);
          end
          vectors++;
          if (vq[c+1] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s valid drop@%0d: got %b want 0", tag, c+2, vq[c+1]);
          end
        end
      end else begin
        ge++;
        vectors++;
        if (eq[c-1] !== 1'b1) begin
          miscompares++;
          $display("FAIL %s frame_err@%0d: got %b want 1", tag, c, eq[c-1]);
        end
      end
    end
    foreach (vq[t]) begin
      if (vq[t] === 1'b1 && (t == 0 || vq[t-1] !== 1'b1)) nv++;
      if (eq[t] === 1'b1) ne++;
      if (oq[t] === 1'b1) no++;
    end
    vectors++;
    if (nv != gv) begin
      miscompares++;
      $display("FAIL %s valid count: got %0d want %0d", tag, nv, gv);
    end
    vectors++;
    if (ne != ge) begin
      miscompares++;
      $display("FAIL %s frame_err count: got %0d want %0d", tag, ne, ge);
    end
    vectors++;
    if (no != 0) begin
      miscompares++;
      $display("FAIL %s overrun count: got %0d want 0", tag, no);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if ({valid_out, busy, frame_err, overrun} !== 4'b0 || data_out !== '0) begin
      miscompares++;
      $display("FAIL %s outputs: valid=%b busy=%b err=%b ovr=%b data=%h, want all 0",
               tag, valid_out, busy, frame_err, overrun, data_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in = 1'b0; ready_in = 1'b1;
    #2;
    check_idle_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_held");
    rst = 1'b0;
    step(1'b1, 1'b0);
    check_idle_outputs("reset_release");
  endtask

  task automatic test_clean();
    int first = -1;
    smp.delete();
    gen_frame(8'hA5, 1'b0, 0);
    model();
    run(0, 4);
    check_events("clean");
    foreach (vq[t]) if (vq[t] === 1'b1 && first < 0) first = t + 1;
    vectors++;
    if (first != OSR*NW + 1) begin
      miscompares++;
      $display("FAIL clean latency: valid at %0d want %0d", first, OSR*NW+1);
    end
    vectors++;
    if (first < 1 || dq[first-1] !== 8'hA5) begin
      miscompares++;
      $display("FAIL clean data: got %h want a5", (first < 1) ? 8'h00 : dq[first-1]);
    end
  endtask

  task automatic test_noise();
    int first = -1;
    smp.delete();
    gen_frame(8'h3C, 1'b0, 8);
    model();
    run(0, 4);
    check_events("noise");
    foreach (vq[t]) if (vq[t] === 1'b1 && first < 0) first = t + 1;
    vectors++;
    if (first < 1 || dq[first-1] !== 8'h3C) begin
      miscompares++;
      $display("FAIL noise data: valid at %0d data %h want 3c", first,
               (first < 1) ? 8'h00 : dq[first-1]);
    end
  endtask

  task automatic test_false_start();
    smp.delete();
    repeat (5) smp.push_back(1'b1);
    repeat (40) smp.push_back(1'b0);
    model();
    run(0, 4);
    check_events("false_start");
    vectors++;
    if (bq[0] !== 1'b1 || bq[OSR-2] !== 1'b1) begin
      miscompares++;
      $display("FAIL false_start busy window: got %b/%b want 1/1", bq[0], bq[OSR-2]);
    end
    vectors++;
    if (bq[OSR-1] !== 1'b0 || bq[OSR+5] !== 1'b0) begin
      miscompares++;
      $display("FAIL false_start idle: got %b/%b want 0/0", bq[OSR-1], bq[OSR+5]);
    end
  endtask

  task automatic test_bad_stop();
    smp.delete();
    gen_frame(8'h81, 1'b1, 0);
    model();
    run(0, 4);
    check_events("bad_stop");
    vectors++;
    if (eq[OSR*NW-1] !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_stop pulse@%0d: got %b want 1", OSR*NW, eq[OSR*NW-1]);
    end
  endtask

  task automatic test_overrun();
    int c1, c2, no = 0;
    ready_in = 1'b0;
    smp.delete();
    gen_frame(8'h11, 1'b0, 0);
    gen_frame(8'h22, 1'b0, 0);
    model();
    run(0, 4);
    vectors++;
    if (ev_kind.size() != 2) begin
      miscompares++;
      $display("FAIL overrun model events: got %0d want 2", ev_kind.size());
    end else begin
      c1 = sstep[ev_idx[0]];
      c2 = sstep[ev_idx[1]];
      vectors++;
      if (vq[c1] !== 1'b1 || dq[c1] !== 8'h11) begin
        miscompares++;
        $display("FAIL overrun first: valid=%b data=%h want 1/11", vq[c1], dq[c1]);
      end
      vectors++;
      if (oq[c2] !== 1'b1) begin
        miscompares++;
        $display("FAIL overrun pulse@%0d: got %b want 1", c2+1, oq[c2]);
      end
      vectors++;
      if (vq[c2] !== 1'b1 || dq[c2] !== 8'h11) begin
        miscompares++;
        $display("FAIL overrun hold: valid=%b data=%h want 1/11", vq[c2], dq[c2]);
      end
    end
    foreach (oq[t]) if (oq[t] === 1'b1) no++;
    vectors++;
    if (no != 1) begin
      miscompares++;
      $display("FAIL overrun count: got %0d want 1", no);
    end
    ready_in = 1'b1;
    step(1'b1, 1'b0);
    vectors++;
    if (vq[vq.size()-1] !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun accept: valid=%b want 0", vq[vq.size()-1]);
    end
  endtask

  task automatic test_back_to_back();
    smp.delete();
    for (int f = 0; f < 4; f++)
      gen_frame(8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 8));
    model();
    run(2, 4);
    check_events("back_to_back");
  endtask

  task automatic test_reset_stall();
    int first = -1;
    ready_in = 1'b0;
    smp.delete();
    gen_frame(8'h77, 1'b0, 0);
    gen_frame(8'h0F, 1'b0, 0);
    smp = smp[0 : OSR*NW + 60];
    run(0, 0);
    vectors++;
    if (valid_out !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stall pre-reset: valid=%b busy=%b want 1/1", valid_out, busy);
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_frame_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_in = 1'b1;
    smp.delete();
    gen_frame(8'h5A, 1'b0, 0);
    model();
    run(1, 4);
    check_events("stall");
    foreach (vq[t]) if (vq[t] === 1'b1 && first < 0) first = t + 1;
    vectors++;
    if (first != 2*OSR*NW || first < 1 || dq[first-1] !== 8'h5A) begin
      miscompares++;
      $display("FAIL stall word: valid at %0d data %h want %0d/5a", first,
               (first < 1) ? 8'h00 : dq[first-1], 2*OSR*NW);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_noise();
    test_false_start();
    test_bad_stop();
    test_overrun();
    test_back_to_back();
    test_reset_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
